// File: rtl/serdesphy_rx_frame_align.sv
// RX frame aligner: hunts a sync word at any bit offset, confirms it at the frame
// period, and emits payload nibbles while locked; re-hunts after repeated misses.
module serdesphy_rx_frame_align #(
   parameter logic [7:0] SYNC_WORD = 8'hD2,
   parameter int         FRAME_LEN = 8,
   parameter int         LOCK_GOOD = 2,
   parameter int         LOSS_BAD  = 3
) (
   input  logic       i_clk_240m_rx,
   input  logic       i_rst_240m_rx,
   input  logic       i_rx_serial_data,
   input  logic       i_rx_serial_valid,
   input  logic       i_rx_serial_error,
   input  logic       i_rx_align_rst,
   output logic [3:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_aligned,
   output logic [1:0] o_align_state,
   output logic       o_sync_miss,
   output logic       o_rx_error
);

   localparam int POS_W = $clog2(FRAME_LEN * 4);
   localparam logic [POS_W-1:0] LP_POS_LAST     = POS_W'(FRAME_LEN * 4 - 1);
   localparam logic [POS_W-1:0] LP_POS_SYNC_END = POS_W'(7);
   localparam logic [POS_W-1:0] LP_POS_PAY      = POS_W'(8);
   localparam logic [POS_W-1:0] LP_POS_ONE      = POS_W'(1);
   localparam logic [3:0]       LP_LOCK_GOOD    = 4'(LOCK_GOOD);
   localparam logic [3:0]       LP_LOSS_BAD     = 4'(LOSS_BAD);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // Only the low 7 history bits are ever looked at; the 8th comes from the live input.
   logic [6:0]       r_sr;
   logic [3:0]       r_fill;
   logic [POS_W-1:0] r_pos;
   logic [3:0]       r_good;
   logic [3:0]       r_bad;
   logic [1:0]       r_state;
   logic [3:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_aligned;
   logic             r_sync_miss;
   logic             r_rx_error;

   logic [7:0]       w_cand;
   logic             w_sync_hit;
   logic [6:0]       w_sr_next;
   logic [3:0]       w_fill_next;
   logic [POS_W-1:0] w_pos_next;
   logic [3:0]       w_good_next;
   logic [3:0]       w_bad_next;
   logic [1:0]       w_state_next;
   logic [3:0]       w_rx_data_next;
   logic             w_rx_valid_next;
   logic             w_sync_miss_next;
   logic             w_rx_error_next;

   assign w_cand     = {r_sr, i_rx_serial_data};
   assign w_sync_hit = (w_cand == SYNC_WORD);

   always_comb begin
      w_sr_next        = r_sr;
      w_fill_next      = r_fill;
      w_pos_next       = r_pos;
      w_good_next      = r_good;
      w_bad_next       = r_bad;
      w_state_next     = r_state;
      w_rx_data_next   = r_rx_data;
      w_rx_valid_next  = 1'b0;
      w_sync_miss_next = 1'b0;
      w_rx_error_next  = r_rx_error;

      if (i_rx_serial_valid) begin
         w_sr_next   = w_cand[6:0];
         w_fill_next = (r_fill == 4'd8) ? r_fill : r_fill + 4'd1;
         w_pos_next  = (r_pos == LP_POS_LAST) ? '0 : r_pos + LP_POS_ONE;
         if (i_rx_serial_error) begin
            w_rx_error_next = 1'b1;
         end

         case (r_state)
            ST_HUNT: begin
               if (r_fill >= 4'd7 && w_sync_hit) begin
                  w_state_next = ST_VERIFY;
                  w_pos_next   = LP_POS_PAY;
                  w_good_next  = '0;
               end
            end
            ST_VERIFY: begin
               if (r_pos == LP_POS_SYNC_END) begin
                  if (w_sync_hit) begin
                     w_good_next = r_good + 4'd1;
                     if (r_good + 4'd1 == LP_LOCK_GOOD) begin
                        w_state_next = ST_LOCKED;
                        w_bad_next   = '0;
                     end
                  end else begin
                     w_sync_miss_next = 1'b1;
                     w_state_next     = ST_HUNT;
                     w_fill_next      = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (r_pos == LP_POS_SYNC_END) begin
                  if (w_sync_hit) begin
                     w_bad_next = '0;
                  end else begin
                     w_sync_miss_next = 1'b1;
                     w_bad_next       = r_bad + 4'd1;
                     if (r_bad + 4'd1 == LP_LOSS_BAD) begin
                        w_state_next = ST_HUNT;
                        w_fill_next  = '0;
                     end
                  end
               end
               // Last bit of a payload nibble completes it.
               if (r_pos >= LP_POS_PAY && r_pos[1:0] == 2'b11) begin
                  w_rx_data_next  = {r_sr[2:0], i_rx_serial_data};
                  w_rx_valid_next = 1'b1;
               end
            end
            default: begin
               w_state_next = ST_HUNT;
               w_fill_next  = '0;
            end
         endcase
      end

      // Restart overrides any decision made on the same bit; the shifter keeps running.
      if (i_rx_align_rst) begin
         w_state_next     = ST_HUNT;
         w_fill_next      = '0;
         w_good_next      = '0;
         w_bad_next       = '0;
         w_pos_next       = '0;
         w_rx_error_next  = 1'b0;
         w_rx_valid_next  = 1'b0;
         w_sync_miss_next = 1'b0;
      end
   end

   always_ff @(posedge i_clk_240m_rx or posedge i_rst_240m_rx) begin
      if (i_rst_240m_rx) begin
         r_sr        <= '0;
         r_fill      <= '0;
         r_pos       <= '0;
         r_good      <= '0;
         r_bad       <= '0;
         r_state     <= ST_HUNT;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_aligned   <= 1'b0;
         r_sync_miss <= 1'b0;
         r_rx_error  <= 1'b0;
      end else begin
         r_sr        <= w_sr_next;
         r_fill      <= w_fill_next;
         r_pos       <= w_pos_next;
         r_good      <= w_good_next;
         r_bad       <= w_bad_next;
         r_state     <= w_state_next;
         r_rx_data   <= w_rx_data_next;
         r_rx_valid  <= w_rx_valid_next;
         r_aligned   <= (w_state_next == ST_LOCKED);
         r_sync_miss <= w_sync_miss_next;
         r_rx_error  <= w_rx_error_next;
      end
   end

   assign o_rx_data     = r_rx_data;
   assign o_rx_valid    = r_rx_valid;
   assign o_rx_aligned  = r_aligned;
   assign o_align_state = r_state;
   assign o_sync_miss   = r_sync_miss;
   assign o_rx_error    = r_rx_error;

endmodule

// File: tb/tb_serdesphy_rx_frame_align.sv
// Bench for serdesphy_rx_frame_align: drives framed bit streams and scores emitted
// nibbles against a queue of expected (bit index, value) entries.
module tb_serdesphy_rx_frame_align;

   logic       clk = 1'b0;
   logic       rst;
   logic       d;
   logic       v;
   logic       e;
   logic       arst;
   logic [3:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_rx_aligned;
   logic [1:0] o_align_state;
   logic       o_sync_miss;
   logic       o_rx_error;

   serdesphy_rx_frame_align dut (
      .i_clk_240m_rx     (clk),
      .i_rst_240m_rx     (rst),
      .i_rx_serial_data  (d),
      .i_rx_serial_valid (v),
      .i_rx_serial_error (e),
      .i_rx_align_rst    (arst),
      .o_rx_data         (o_rx_data),
      .o_rx_valid        (o_rx_valid),
      .o_rx_aligned      (o_rx_aligned),
      .o_align_state     (o_align_state),
      .o_sync_miss       (o_sync_miss),
      .o_rx_error        (o_rx_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [3:0] nib;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_err    = 0;
   int  bit_cnt  = 0;
   bit  err_next = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare per-cycle outputs; a strobe is expected only for the bit that completes a queued nibble.
   task automatic sample_outputs(input int my_id, input bit exp_miss);
      sb_t t;
      bit  exp_v;
      exp_v = (sb_q.size() > 0) && (sb_q[0].id == my_id);
      check_val("rx_valid", o_rx_valid, exp_v);
      check_val("sync_miss", o_sync_miss, exp_miss);
      if (exp_v) begin
         t = sb_q.pop_front();
         check_val("rx_data", o_rx_data, t.nib);
         $display("nibble bit=%0d data=%0h", my_id, o_rx_data);
      end
   endtask

   task automatic send_bit(input logic b, input logic arst_in, input bit exp_miss);
      int my_id;
      d        = b;
      v        = 1'b1;
      e        = err_next;
      err_next = 1'b0;
      arst     = arst_in;
      my_id    = bit_cnt;
      bit_cnt++;
      @(posedge clk);
      #1;
      v    = 1'b0;
      e    = 1'b0;
      arst = 1'b0;
      sample_outputs(my_id, exp_miss);
   endtask

   task automatic send_gap(input int n);
      for (int i = 0; i < n; i++) begin
         v = 1'b0;
         @(posedge clk);
         #1;
         sample_outputs(-1, 1'b0);
      end
   endtask

   task automatic send_nib(input logic [3:0] nib, input bit emit, input int gap_max);
      sb_t t;
      for (int i = 3; i >= 0; i--) begin
         if (i == 0 && emit) begin
            t.id  = bit_cnt;
            t.nib = nib;
            sb_q.push_back(t);
         end
         send_bit(nib[i], 1'b0, 1'b0);
         if (gap_max > 0) send_gap($urandom_range(1, gap_max));
      end
   endtask

   // Sync byte, then payload nibbles 1..6; state is checked right after the sync decision.
   task automatic send_frame(input logic [7:0] sw, input bit emit, input bit miss,
                             input logic [1:0] exp_st, input int gap_max, input bit arst_last);
      for (int i = 7; i >= 0; i--) begin
         send_bit(sw[i], (i == 0) && arst_last, (i == 0) && miss);
         if (gap_max > 0) send_gap($urandom_range(1, gap_max));
      end
      check_val("align_state", o_align_state, exp_st);
      check_val("rx_aligned", o_rx_aligned, exp_st == 2'd2);
      for (int n = 1; n <= 6; n++) begin
         send_nib(4'(n), emit, gap_max);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_rx_data"}, o_rx_data, 0);
      check_val({tag, "_rx_valid"}, o_rx_valid, 0);
      check_val({tag, "_rx_aligned"}, o_rx_aligned, 0);
      check_val({tag, "_align_state"}, o_align_state, 0);
      check_val({tag, "_sync_miss"}, o_sync_miss, 0);
      check_val({tag, "_rx_error"}, o_rx_error, 0);
   endtask

   localparam logic [7:0] GOOD = 8'hD2;
   localparam logic [7:0] BAD  = 8'hD3;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sw;
      rst  = 1'b1;
      d    = 1'b0;
      v    = 1'b0;
      e    = 1'b0;
      arst = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Acquisition at a 3-bit offset; lock on the third sync, payload only from then on.
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 0, 1'b0);

      // Two misses stay locked and keep emitting.
      send_frame(BAD,  1'b1, 1'b1, 2'd2, 0, 1'b0);
      send_frame(BAD,  1'b1, 1'b1, 2'd2, 0, 1'b0);
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 0, 1'b0);

      // Valid gaps while locked.
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 5, 1'b0);
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 5, 1'b0);

      // Three misses drop lock; re-lock afterwards.
      send_frame(BAD,  1'b1, 1'b1, 2'd2, 0, 1'b0);
      send_frame(BAD,  1'b1, 1'b1, 2'd2, 0, 1'b0);
      send_frame(BAD,  1'b0, 1'b1, 2'd0, 0, 1'b0);
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 0, 1'b0);

      // Sticky error, then synchronous restart.
      err_next = 1'b1;
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 0, 1'b0);
      check_val("rx_error_sticky", o_rx_error, 1);
      arst = 1'b1;
      v    = 1'b0;
      @(posedge clk);
      #1;
      arst = 1'b0;
      sample_outputs(-1, 1'b0);
      check_val("arst_rx_error", o_rx_error, 0);
      check_val("arst_state", o_align_state, 0);
      check_val("arst_aligned", o_rx_aligned, 0);

      // Miss while verifying, then restart colliding with a hunt match.
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(BAD,  1'b0, 1'b1, 2'd0, 0, 1'b0);
      send_frame(GOOD, 1'b0, 1'b0, 2'd0, 0, 1'b1);
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(GOOD, 1'b0, 1'b0, 2'd1, 0, 1'b0);
      send_frame(GOOD, 1'b1, 1'b0, 2'd2, 0, 1'b0);
      check_val("sb_empty", sb_q.size(), 0);

      // Asynchronous reset mid-payload, between clock edges.
      sw = GOOD;
      for (int i = 7; i >= 0; i--) send_bit(sw[i], 1'b0, 1'b0);
      check_val("pre_rst_state", o_align_state, 2);
      err_next = 1'b1;
      send_nib(4'd1, 1'b1, 0);
      send_nib(4'd2, 1'b1, 0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      check_val("pre_rst_rx_data", o_rx_data, 2);
      check_val("pre_rst_rx_error", o_rx_error, 1);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_val("rst_hold_state", o_align_state, 0);
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
